pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 8, program-counter width in bits.
REQ-002 Parameter OFF_W, default 8, branch-offset width (two's complement), OFF_W <= PC_W.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries, >= 1.
REQ-004 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-005 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1, one clock; reset is synchronous and active-low.
REQ-007 Port halt, input, 1, request to enter HALTED.
REQ-008 Port resume, input, 1, request to leave HALTED.
REQ-009 Port br_valid, input, 1, a control-flow instruction is present this cycle.
REQ-010 Port br_mode, input, 3, 0 BLT, 1 BNE, 2 BEQ, 3 BGE, 4 JREL, 5 JABS, 6 CALL, 7 RET.
REQ-011 Port cmp_lt, input, 1, comparison flag "less than".
REQ-012 Port cmp_eq, input, 1, comparison flag "equal".
REQ-013 Port br_off, input, OFF_W, signed relative offset.
REQ-014 Port br_target, input, PC_W, absolute target for JABS and CALL.
REQ-015 Port pc, output, PC_W, current fetch address (registered).
REQ-016 Port halted, output, 1, high while in HALTED.
REQ-017 Port taken, output, 1, registered; high for the cycle after a redirect was taken.
REQ-018 Port ras_err, output, 1, sticky stack overflow/underflow flag.

Function
REQ-019 The FSM SHALL have two states: RUN and HALTED.
REQ-020 In RUN, halt=1 SHALL hold pc, move to HALTED next cycle, and discard any br_valid in that cycle.
REQ-021 In HALTED, pc and the stack SHALL hold; resume=1 with halt=0 SHALL return to RUN; halt=1 SHALL keep HALTED regardless of resume.
REQ-022 In RUN with halt=0 and br_valid=0, pc SHALL become pc+1 modulo 2^PC_W.
REQ-023 Conditional modes SHALL be taken when BLT: cmp_lt=1; BNE: cmp_eq=0; BEQ: cmp_eq=1; BGE: cmp_lt=0.
REQ-024 A taken conditional or JREL SHALL set pc to pc + sign_extend(br_off) modulo 2^PC_W; a not-taken conditional SHALL set pc to pc+1.
REQ-025 JABS SHALL set pc to br_target.
REQ-026 If the stack is not full, CALL SHALL push pc+1 (mod 2^PC_W) and set pc to br_target.
REQ-027 If the stack holds RAS_DEPTH entries, CALL SHALL set ras_err, leave the stack unchanged, and still set pc to br_target.
REQ-028 If the stack is not empty, RET SHALL pop the top entry into pc.
REQ-029 If the stack is empty, RET SHALL set ras_err, leave the stack unchanged, and set pc to pc+1.
REQ-030 The stack SHALL be LIFO, with occupancy count 0..RAS_DEPTH; at most one push or pop per cycle.
REQ-031 taken SHALL be 1 in the cycle after any cycle in which pc was loaded by a taken conditional, JREL, JABS, CALL or successful RET, and 0 otherwise.
REQ-032 Latency: every redirect SHALL be visible on pc exactly one cycle after its br_valid cycle; there SHALL be no combinational path from inputs to outputs.
REQ-033 Offset 0 on a taken branch SHALL leave pc unchanged and still assert taken.
REQ-034 Once set, ras_err SHALL clear only on reset.

Reset
REQ-035 When reset=0 at a clock edge, the block SHALL set pc=RESET_PC, state=RUN, halted=0, taken=0, ras_err=0 and stack occupancy=0, overriding all other inputs.
REQ-036 A reset in HALTED or between a CALL and its RET SHALL discard the stack contents; the next RET SHALL underflow.

Verification
REQ-037 With default parameters, release reset and idle for 260 cycles -> pc runs 0,1,...,255,0,1,2,3 (wrap) with taken=0 throughout.
REQ-038 At pc=0x10, BLT with br_off=0xFC and cmp_lt=1 -> pc=0x0C, taken=1; at pc=0x10, BNE with cmp_eq=1 -> pc=0x11, taken=0.
REQ-039 At pc=0x20, CALL with br_target=0x80, then at 0x80 RET -> pc=0x80 then 0x21; five nested CALLs with RAS_DEPTH=4 -> ras_err=1 and four RETs return the first four addresses in LIFO order.
REQ-040 halt and br_valid (JABS 0x40) in the same cycle at pc=0x05 -> pc holds 0x05 and halted=1; resume -> pc=0x06 on the first RUN cycle.
REQ-041 Reset asserted in HALTED with two entries on the stack -> pc=RESET_PC, halted=0, ras_err=0; an immediate RET -> ras_err=1, pc=RESET_PC+1.
REQ-042 With PC_W=12 and OFF_W=6: at pc=0x002, JREL br_off=0x3C (-4) -> pc=0xFFE (wrap), taken=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increments, branches, jumps, CALL/RET through a return-address stack, halt/resume.
// Latency: every redirect or increment appears on pc one clock after the cycle that requested it; all outputs are registered.
// Backpressure: none; halt freezes pc and the stack, and a control-flow instruction offered while halt=1 is dropped.
//
// Ports:
//   clk, reset (synchronous, active-low)
//   halt, resume          - enter / leave the HALTED state
//   br_valid, br_mode     - control-flow instruction present and its kind
//                           (0 BLT, 1 BNE, 2 BEQ, 3 BGE, 4 JREL, 5 JABS, 6 CALL, 7 RET)
//   cmp_lt, cmp_eq        - comparison flags for the conditional modes
//   br_off, br_target     - signed relative offset / absolute target
//   pc, halted, taken     - registered fetch address, state flag, redirect-taken flag
//   ras_err               - sticky return-stack overflow/underflow flag
module pc_sequencer #(
    parameter int              PC_W      = 8,
    parameter int              OFF_W     = 8,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             halt,
    input  logic             resume,
    input  logic             br_valid,
    input  logic [2:0]       br_mode,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    input  logic [OFF_W-1:0] br_off,
    input  logic [PC_W-1:0]  br_target,
    output logic [PC_W-1:0]  pc,
    output logic             halted,
    output logic             taken,
    output logic             ras_err
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    localparam logic [2:0] M_BLT  = 3'd0;
    localparam logic [2:0] M_BNE  = 3'd1;
    localparam logic [2:0] M_BEQ  = 3'd2;
    localparam logic [2:0] M_BGE  = 3'd3;
    localparam logic [2:0] M_JREL = 3'd4;
    localparam logic [2:0] M_JABS = 3'd5;
    localparam logic [2:0] M_CALL = 3'd6;
    localparam logic [2:0] M_RET  = 3'd7;

    logic [0:0]       state, state_nxt;
    logic [PC_W-1:0]  pc_nxt;
    logic             taken_nxt;
    logic             err_nxt;
    logic             push, pop;
    logic [CNT_W-1:0] count;
    logic [PC_W-1:0]  ras [RAS_DEPTH];

    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  pc_rel;
    logic [PC_W-1:0]  off_ext;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             full, empty;
    logic             cond_take;

    // Sized cast of a signed operand sign-extends; works for OFF_W == PC_W too.
    assign off_ext = PC_W'($signed(br_off));
    assign pc_inc  = pc + PC_W'(1);
    assign pc_rel  = pc + off_ext;

    assign full   = (count == CNT_W'(RAS_DEPTH));
    assign empty  = (count == '0);
    assign wr_idx = IDX_W'(count);
    assign rd_idx = IDX_W'(count - CNT_W'(1));

    always_comb begin
        cond_take = 1'b0;
        case (br_mode)
            M_BLT:   cond_take = cmp_lt;
            M_BNE:   cond_take = !cmp_eq;
            M_BEQ:   cond_take = cmp_eq;
            M_BGE:   cond_take = !cmp_lt;
            default: cond_take = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        taken_nxt = 1'b0;
        err_nxt   = ras_err;
        push      = 1'b0;
        pop       = 1'b0;
        case (state)
            ST_RUN: begin
                if (halt) begin
                    // pc holds and any instruction offered this cycle is dropped.
                    state_nxt = ST_HALTED;
                end else begin
                    pc_nxt = pc_inc;
                    if (br_valid) begin
                        case (br_mode)
                            M_BLT, M_BNE, M_BEQ, M_BGE: begin
                                if (cond_take) begin
                                    pc_nxt    = pc_rel;
                                    taken_nxt = 1'b1;
                                end
                            end
                            M_JREL: begin
                                pc_nxt    = pc_rel;
                                taken_nxt = 1'b1;
                            end
                            M_JABS: begin
                                pc_nxt    = br_target;
                                taken_nxt = 1'b1;
                            end
                            M_CALL: begin
                                // Overflow still jumps; only the return address is lost.
                                if (full) err_nxt = 1'b1;
                                else      push    = 1'b1;
                                pc_nxt    = br_target;
                                taken_nxt = 1'b1;
                            end
                            default: begin // M_RET
                                if (empty) begin
                                    err_nxt = 1'b1; // falls through to pc+1
                                end else begin
                                    pop       = 1'b1;
                                    pc_nxt    = ras[rd_idx];
                                    taken_nxt = 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
            default: begin // ST_HALTED
                if (!halt && resume) state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_RUN;
            pc      <= RESET_PC;
            taken   <= 1'b0;
            ras_err <= 1'b0;
            count   <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            taken   <= taken_nxt;
            ras_err <= err_nxt;
            if (push)     count <= count + CNT_W'(1);
            else if (pop) count <= count - CNT_W'(1);
        end
    end

    // Stack storage needs no reset: clearing count is enough to discard it.
    always_ff @(posedge clk) begin
        if (reset && push) ras[wr_idx] <= pc_inc;
    end

    assign halted = (state == ST_HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam logic [2:0] M_BLT  = 3'd0;
    localparam logic [2:0] M_BNE  = 3'd1;
    localparam logic [2:0] M_BEQ  = 3'd2;
    localparam logic [2:0] M_BGE  = 3'd3;
    localparam logic [2:0] M_JREL = 3'd4;
    localparam logic [2:0] M_JABS = 3'd5;
    localparam logic [2:0] M_CALL = 3'd6;
    localparam logic [2:0] M_RET  = 3'd7;

    logic        clk;
    logic        reset;
    logic        halt, resume, br_valid, cmp_lt, cmp_eq;
    logic [2:0]  br_mode;
    logic [7:0]  br_off, br_target;
    logic [7:0]  pc;
    logic        halted, taken, ras_err;

    // Second instance: 12-bit pc, 6-bit offset.
    logic        br_valid2;
    logic [2:0]  br_mode2;
    logic [5:0]  br_off2;
    logic [11:0] br_target2;
    logic [11:0] pc2;
    logic        halted2, taken2, ras_err2;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .halt(halt), .resume(resume),
        .br_valid(br_valid), .br_mode(br_mode), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
        .br_off(br_off), .br_target(br_target),
        .pc(pc), .halted(halted), .taken(taken), .ras_err(ras_err)
    );

    pc_sequencer #(.PC_W(12), .OFF_W(6), .RAS_DEPTH(4), .RESET_PC(12'h000)) dut2 (
        .clk(clk), .reset(reset), .halt(1'b0), .resume(1'b0),
        .br_valid(br_valid2), .br_mode(br_mode2), .cmp_lt(1'b0), .cmp_eq(1'b0),
        .br_off(br_off2), .br_target(br_target2),
        .pc(pc2), .halted(halted2), .taken(taken2), .ras_err(ras_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs to the 8-bit instance, then sample 1 time unit after the edge.
    task automatic step(input logic h, input logic r, input logic bv, input logic [2:0] m,
                        input logic lt, input logic eq, input logic [7:0] off, input logic [7:0] tgt);
        halt = h; resume = r; br_valid = bv; br_mode = m;
        cmp_lt = lt; cmp_eq = eq; br_off = off; br_target = tgt;
        @(posedge clk);
        #1;
        halt = 1'b0; resume = 1'b0; br_valid = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic br(input logic [2:0] m, input logic lt, input logic eq,
                      input logic [7:0] off, input logic [7:0] tgt);
        step(1'b0, 1'b0, 1'b1, m, lt, eq, off, tgt);
    endtask

    initial begin
        logic [7:0] exp_pc;
        reset = 1'b0;
        halt = 1'b0; resume = 1'b0; br_valid = 1'b0; br_mode = 3'd0;
        cmp_lt = 1'b0; cmp_eq = 1'b0; br_off = 8'h00; br_target = 8'h00;
        br_valid2 = 1'b0; br_mode2 = 3'd0; br_off2 = 6'h00; br_target2 = 12'h000;

        // Reset state, with a branch offered to show reset overrides it.
        br(M_JABS, 1'b0, 1'b0, 8'h00, 8'h77);
        idle();
        check("rst_pc", pc, 8'h00);
        check("rst_halted", halted, 1'b0);
        check("rst_taken", taken, 1'b0);
        check("rst_err", ras_err, 1'b0);
        check("rst_pc2", pc2, 12'h000);

        // Free-running count with wrap.
        #1 reset = 1'b1;
        for (int i = 0; i < 260; i++) begin
            exp_pc = i[7:0];
            check("run_pc", pc, exp_pc);
            check("run_taken", taken, 1'b0);
            idle();
        end
        check("run_wrap_end", pc, 8'h04);

        // Conditional branches.
        br(M_JABS, 1'b0, 1'b0, 8'h00, 8'h10);
        check("jabs_pc", pc, 8'h10);
        check("jabs_taken", taken, 1'b1);
        br(M_BLT, 1'b1, 1'b0, 8'hFC, 8'h00);
        check("blt_pc", pc, 8'h0C);
        check("blt_taken", taken, 1'b1);
        br(M_JABS, 1'b0, 1'b0, 8'h00, 8'h10);
        br(M_BNE, 1'b0, 1'b1, 8'h08, 8'h00);
        check("bne_nt_pc", pc, 8'h11);
        check("bne_nt_taken", taken, 1'b0);
        br(M_BEQ, 1'b0, 1'b1, 8'h00, 8'h00);
        check("beq_off0_pc", pc, 8'h11);
        check("beq_off0_taken", taken, 1'b1);
        br(M_BGE, 1'b1, 1'b0, 8'h05, 8'h00);
        check("bge_nt_pc", pc, 8'h12);
        check("bge_nt_taken", taken, 1'b0);
        br(M_BGE, 1'b0, 1'b0, 8'h02, 8'h00);
        check("bge_t_pc", pc, 8'h14);
        br(M_JREL, 1'b0, 1'b0, 8'h7F, 8'h00);
        check("jrel_pc", pc, 8'h93);
        idle();
        check("idle_taken", taken, 1'b0);

        // CALL / RET.
        br(M_JABS, 1'b0, 1'b0, 8'h00, 8'h20);
        br(M_CALL, 1'b0, 1'b0, 8'h00, 8'h80);
        check("call_pc", pc, 8'h80);
        check("call_taken", taken, 1'b1);
        br(M_RET, 1'b0, 1'b0, 8'h00, 8'h00);
        check("ret_pc", pc, 8'h21);
        check("ret_taken", taken, 1'b1);

        // Five nested calls into a four-entry stack.
        br(M_CALL, 1'b0, 1'b0, 8'h00, 8'h40);
        br(M_CALL, 1'b0, 1'b0, 8'h00, 8'h50);
        br(M_CALL, 1'b0, 1'b0, 8'h00, 8'h60);
        br(M_CALL, 1'b0, 1'b0, 8'h00, 8'h70);
        check("nest4_err", ras_err, 1'b0);
        br(M_CALL, 1'b0, 1'b0, 8'h00, 8'h90);
        check("ovf_pc", pc, 8'h90);
        check("ovf_taken", taken, 1'b1);
        check("ovf_err", ras_err, 1'b1);
        br(M_RET, 1'b0, 1'b0, 8'h00, 8'h00);
        check("ret1_pc", pc, 8'h61);
        br(M_RET, 1'b0, 1'b0, 8'h00, 8'h00);
        check("ret2_pc", pc, 8'h51);
        br(M_RET, 1'b0, 1'b0, 8'h00, 8'h00);
        check("ret3_pc", pc, 8'h41);
        br(M_RET, 1'b0, 1'b0, 8'h00, 8'h00);
        check("ret4_pc", pc, 8'h22);
        br(M_RET, 1'b0, 1'b0, 8'h00, 8'h00);
        check("unf_pc", pc, 8'h23);
        check("unf_taken", taken, 1'b0);
        idle();
        check("err_sticky", ras_err, 1'b1);

        // Halt wins over a same-cycle jump; resume.
        br(M_JABS, 1'b0, 1'b0, 8'h00, 8'h05);
        step(1'b1, 1'b0, 1'b1, M_JABS, 1'b0, 1'b0, 8'h00, 8'h40);
        check("halt_pc", pc, 8'h05);
        check("halt_flag", halted, 1'b1);
        check("halt_taken", taken, 1'b0);
        step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("halt_over_resume", halted, 1'b1);
        br(M_JABS, 1'b0, 1'b0, 8'h00, 8'h40);
        check("halted_hold_pc", pc, 8'h05);
        step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("resume_flag", halted, 1'b0);
        check("resume_pc_hold", pc, 8'h05);
        idle();
        check("first_run_pc", pc, 8'h06);

        // Reset in HALTED with two stacked return addresses.
        br(M_CALL, 1'b0, 1'b0, 8'h00, 8'h30);
        br(M_CALL, 1'b0, 1'b0, 8'h00, 8'h38);
        step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("pre_rst_halted", halted, 1'b1);
        reset = 1'b0;
        idle();
        reset = 1'b1;
        check("rst2_pc", pc, 8'h00);
        check("rst2_halted", halted, 1'b0);
        check("rst2_err", ras_err, 1'b0);
        br(M_RET, 1'b0, 1'b0, 8'h00, 8'h00);
        check("rst2_ret_err", ras_err, 1'b1);
        check("rst2_ret_pc", pc, 8'h01);
        check("rst2_ret_taken", taken, 1'b0);

        // 12-bit pc, 6-bit offset: negative offset wraps below zero.
        br_valid2 = 1'b1; br_mode2 = M_JABS; br_target2 = 12'h002;
        @(posedge clk); #1;
        check("w12_jabs_pc", pc2, 12'h002);
        br_mode2 = M_JREL; br_off2 = 6'h3C;
        @(posedge clk); #1;
        br_valid2 = 1'b0;
        check("w12_jrel_pc", pc2, 12'hFFE);
        check("w12_jrel_taken", taken2, 1'b1);
        @(posedge clk); #1;
        check("w12_inc_pc", pc2, 12'hFFF);
        @(posedge clk); #1;
        check("w12_wrap_pc", pc2, 12'h000);
        check("w12_err", ras_err2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
